// File: rtl/deser_1to8.sv
// deser_1to8: serial-to-parallel receiver. Collects one bit per accepted
// input beat into position bit_idx (LSB first) and presents each completed
// word on a valid/ready output port. The output register doubles as a
// one-word skid buffer, so the next word can be assembled while the previous
// one waits for its consumer.
module deser_1to8 #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] bit_idx,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   asm_q, asm_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;

  logic at_last;
  logic blocked;
  logic accept;

  // Handshake qualifiers: the final bit of a word is refused only while the
  // skid register still holds an unconsumed word that is not leaving now.
  always_comb begin
    at_last  = (idx_q == LAST_IDX);
    blocked  = at_last && valid_q && !out_ready;
    in_ready = !blocked;
    accept   = in_valid && in_ready;
  end

  // Next-state computation for assembly, index, output word and FSM state.
  always_comb begin
    // NOTE: every signal assigned here gets a hold default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;

    // A consume frees the output register; a completion below may refill it
    // in the same edge, which keeps out_valid high without a bubble.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      // Abort the partial word only; a finished word awaiting the consumer
      // is left alone. A bit offered in this cycle is dropped.
      state_d = IDLE;
      idx_d   = '0;
      asm_d   = '0;
    end else if (accept) begin
      if (at_last) begin
        data_d             = asm_q;
        data_d[WIDTH-1]    = in_bit;
        valid_d            = 1'b1;
        asm_d              = '0;
        idx_d              = '0;
        state_d            = IDLE;
      end else begin
        asm_d[idx_q] = in_bit;
        idx_d        = idx_q + IDX_W'(1);
        state_d      = SHIFT;
      end
    end else if (blocked) begin
      state_d = STALL;
    end else if (state_q == STALL) begin
      state_d = SHIFT;
    end
  end

  // State registers; everything, including the pending output word, clears
  // on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Registered outputs straight from the state flops.
  always_comb begin
    bit_idx   = idx_q;
    out_data  = data_q;
    out_valid = valid_q;
    busy      = (idx_q != '0) || (state_q == SHIFT);
  end

endmodule

// File: doc/deser_1to8.md
Name: deser_1to8

Overview:
- Sequential 1-to-8 demultiplexer and deserializer. It is the receive end of the select-indexed 8-to-1 mux serializer path.
- Accepts one serial bit per handshake and steers it into word position bit_idx, sweeping indices 0..WIDTH-1, LSB first.
- Presents each completed word on a valid/ready output port.
- Sits between a mux-based bit serializer and any parallel word consumer.

Parameters:
- WIDTH, 8, word width in bits; legal values are powers of two from 2 to 32.
- IDX_W, $clog2(WIDTH) (3 at default), width of bit_idx. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Asserts asynchronously; deassertion is synchronised externally.
- clear  input  1  synchronous abort; discards the partial word.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle.
- bit_idx  output  IDX_W  position the next accepted bit will occupy.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer takes out_data this cycle.
- busy  output  1  partial word in progress (bit_idx != 0 or state SHIFT).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, bit_idx=0, assembly register=0.
  - out_data=0, out_valid=0, busy=0.
  - in_ready=1 as soon as reset releases.
- Input accept: an input beat is accepted when in_valid && in_ready at a rising clk edge. Both input signals are sampled only at the edge.
- Bit placement:
  - An accepted bit is written to asm[bit_idx]; other asm bits hold.
  - bit_idx increments modulo WIDTH, so WIDTH-1 wraps to 0.
- States:
  - IDLE: bit_idx=0, no partial word. An accept moves to SHIFT.
  - SHIFT: collecting bits.
    - Accept at bit_idx=WIDTH-1 is the word completion.
    - On completion, out_data <= {in_bit, asm[WIDTH-2:0]} and out_valid<=1; the output updates the edge after the last accept.
    - Then asm<=0, bit_idx<=0, state<=IDLE.
  - STALL: entered when bit_idx=WIDTH-1 && out_valid && !out_ready.
    - in_ready=0; the final bit is not accepted, so no data is lost.
    - Exits to SHIFT the cycle out_ready is sampled high.
- in_ready = !(bit_idx==WIDTH-1 && out_valid && !out_ready).
  - This is combinational from out_ready.
  - The output register acts as a one-word skid: the next word may be collected while the previous one is held.
- Output handshake:
  - out_valid && out_ready at an edge consumes the word; out_valid<=0 unless a completion occurs in the same edge.
  - Simultaneous completion and consume: the new word loads and out_valid stays 1 with no bubble.
  - out_data is stable while out_valid && !out_ready.
- clear:
  - asm<=0, bit_idx<=0, state<=IDLE.
  - out_data and out_valid are untouched.
  - clear takes priority over an input accept in the same cycle; that bit is dropped.
- Reset mid-word or mid-stall: everything returns to reset values, including any pending out word.
- in_bit is don't-care when in_valid=0. Idle cycles between beats are allowed and hold all state.

Test Plan:
- Basic word, WIDTH=8:
  - After reset, feed bits 1,0,1,1,1,0,0,1 on 8 consecutive cycles with out_ready=1.
  - Expect bit_idx stepping 0..7 then 0, and out_data=8'h9D with out_valid=1 for exactly one cycle, one cycle after the 8th accept.
- Gapped input: same word with in_valid low on alternate cycles.
  - Expect out_data=8'h9D, and bit_idx held during the gaps.
- Backpressure:
  - Hold out_ready=0. Send word 8'hA5, then 7 bits of word 8'h3C.
  - Expect in_ready=0 at bit_idx=7, out_data stable at 8'hA5.
  - Raise out_ready for 1 cycle: 8'hA5 consumed, the 8th bit accepted next, out_data=8'h3C.
- Back-to-back with out_ready=1:
  - Send 8'hFF then 8'h00 continuously.
  - Expect out_valid high on two cycles 8 apart, in_ready never low.
- clear mid-word:
  - After 5 bits, pulse clear together with in_valid.
  - Expect bit_idx=0, busy=0, and the next full word 8'h81 received intact with no stale bits.
- Async reset during STALL:
  - Drop rst_n between clock edges.
  - Expect out_valid=0, out_data=0, bit_idx=0 immediately without waiting for a clock edge, and in_ready=1 after release.
